// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state codes, RV32I funct3
// codes for memory accesses, the default bus timeout and access-decode helpers.
package lsu_pkg;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_BUS  = 2'd1;
  localparam lsu_state_t ST_DONE = 2'd2;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int unsigned TIMEOUT_CYC_DEF = 16;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (f3)
        SB, SH, SW: ok = 1'b1;
        default:    ok = 1'b0;
      endcase
    end else begin
      case (f3)
        LB, LH, LW, LBU, LHU: ok = 1'b1;
        default:              ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Only meaningful for legal codes; illegal codes are rejected before this matters.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    case (f3)
      LH, LHU: mis = a[0];
      LW:      mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication, load lane
// extraction with sign/zero extension. No state, no backpressure.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    load_o = rdata_i;
    case (funct3_i)
      LB:      load_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      load_o = {{16{half_sel[15]}}, half_sel};
      LBU:     load_o = {24'd0, byte_sel};
      LHU:     load_o = {16'd0, half_sel};
      default: load_o = rdata_i;
    endcase
  end

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: wdata_o = {4{wdata_i[7:0]}};
      2'b01: wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = wdata_i;
    endcase
    if (is_store_i) begin
      case (funct3_i[1:0])
        2'b00:   be_o = 4'b0001 << addr_lo_i;
        2'b01:   be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        default: be_o = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE -> BUS -> DONE, done two cycles after start at best.
// Holds the bus request until ack or TIMEOUT_CYC cycles; starts while busy are dropped.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_rw,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata_wb,
  output logic        misalign,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mis_q, mis_d;
  logic             err_q, err_d;

  logic [3:0]  be_w;
  logic [31:0] wrep_w;
  logic [31:0] load_w;
  logic        in_bus;

  lsu_align u_align (
    .is_store_i (we_q),
    .funct3_i   (f3_q),
    .addr_lo_i  (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (bus_rdata),
    .be_o       (be_w),
    .wdata_o    (wrep_w),
    .load_o     (load_w)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        mis_d = 1'b0;
        err_d = 1'b0;
        cnt_d = '0;
        if (start) begin
          // Illegal codes take priority: their access size is undefined.
          if (!f3_legal(mem_rw, funct3)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (f3_misaligned(funct3, addr[1:0])) begin
            mis_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            we_d    = mem_rw;
            f3_d    = funct3;
            addr_d  = addr;
            wdata_d = wdata;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (bus_ack) begin
          if (!we_q) rdata_d = load_w;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        mis_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        mis_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs are decoded from state so reset removes the request immediately.
  assign in_bus    = (state_q == ST_BUS);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign misalign  = done & mis_q;
  assign err       = done & err_q;
  assign rdata_wb  = rdata_q;
  assign bus_req   = in_bus;
  assign bus_we    = in_bus & we_q;
  assign bus_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_wdata = (in_bus & we_q) ? wrep_w : 32'd0;
  assign bus_be    = in_bus ? be_w : 4'b0000;

endmodule
